word_lane_serializer: RTL and testbench

//   Parametrised successor of the word splitter: accepts one DATA_W word plus per-lane byte enables
//   and emits its enabled LANE_W lanes one per cycle over a valid/ready stream.

---
 rtl/word_lane_serializer_pkg.sv | 18 +
 rtl/word_lane_serializer_lane_pick.sv | 55 +++++
 rtl/word_lane_serializer.sv | 94 +++++++++
 tb/tb_word_lane_serializer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/word_lane_serializer_pkg.sv
// Shared definitions for the word lane serializer: lane order encoding,
// default geometry and a single-bit test helper.
package word_lane_serializer_pkg;

  typedef enum logic {
    LANE_LSB_FIRST = 1'b0,
    LANE_MSB_FIRST = 1'b1
  } lane_dir_e;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_LANE_W = 8;

  // True when exactly one bit of v is set (masks up to 64 lanes).
  function automatic logic is_single_bit(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/word_lane_serializer_lane_pick.sv
// Combinational lane selector: picks the highest or lowest remaining lane
// of a mask and flags when it is the only one left.
module lane_pick
  import word_lane_serializer_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NLANES-1:0] mask,
  input  lane_dir_e         dir,
  output logic [IDX_W-1:0]  idx,
  output logic [NLANES-1:0] onehot,
  output logic              last
);

  logic [IDX_W-1:0] hi_idx_s;
  logic [IDX_W-1:0] lo_idx_s;

  // Highest set bit: ascending scan, later hits overwrite earlier ones.
  always_comb begin
    hi_idx_s = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (mask[i]) begin
        hi_idx_s = IDX_W'(i);
      end else begin
        hi_idx_s = hi_idx_s;
      end
    end
  end

  // Lowest set bit: descending scan, later hits overwrite earlier ones.
  always_comb begin
    lo_idx_s = '0;
    for (int i = NLANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lo_idx_s = IDX_W'(i);
      end else begin
        lo_idx_s = lo_idx_s;
      end
    end
  end

  // Select direction and build the one-hot clear vector for the chosen lane.
  always_comb begin
    idx    = (dir == LANE_MSB_FIRST) ? hi_idx_s : lo_idx_s;
    onehot = '0;
    if (|mask) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = '0;
    end
    last = is_single_bit(64'(mask));
  end

endmodule

// File: rtl/word_lane_serializer.sv
// Splits a DATA_W word into its enabled LANE_W lanes and streams them one
// per cycle, highest-first or lowest-first as chosen per word.
module word_lane_serializer
  import word_lane_serializer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int LANE_W = DEFAULT_LANE_W,
  localparam int NLANES = DATA_W / LANE_W,
  localparam int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [NLANES-1:0] in_be,
  input  logic              msb_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy
);

  logic [DATA_W-1:0] data_r;
  logic [NLANES-1:0] mask_r;
  lane_dir_e         dir_r;

  logic [IDX_W-1:0]  pick_idx_s;
  logic [NLANES-1:0] pick_onehot_s;
  logic              pick_last_s;
  logic [LANE_W-1:0] lane_s;
  logic              accept_s;
  logic              lane_fire_s;

  lane_pick #(
    .NLANES (NLANES),
    .IDX_W  (IDX_W)
  ) u_lane_pick (
    .mask   (mask_r),
    .dir    (dir_r),
    .idx    (pick_idx_s),
    .onehot (pick_onehot_s),
    .last   (pick_last_s)
  );

  // Lane mux, output gating and handshake qualifiers.
  always_comb begin
    lane_s = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (pick_idx_s == IDX_W'(i)) begin
        lane_s = data_r[i*LANE_W +: LANE_W];
      end else begin
        lane_s = lane_s;
      end
    end

    out_valid   = |mask_r;
    busy        = out_valid;
    lane_fire_s = out_valid & out_ready;
    // A new word may slide in on the same edge the final lane leaves.
    in_ready    = ~reset & ((mask_r == '0) | (lane_fire_s & pick_last_s));
    accept_s    = in_valid & in_ready;

    if (out_valid) begin
      out_data = lane_s;
      out_idx  = pick_idx_s;
      out_last = pick_last_s;
    end else begin
      out_data = '0;
      out_idx  = '0;
      out_last = 1'b0;
    end
  end

  // Word capture and remaining-lane bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= '0;
      mask_r <= '0;
      dir_r  <= LANE_LSB_FIRST;
    end else if (accept_s) begin
      data_r <= in_data;
      mask_r <= in_be;
      dir_r  <= lane_dir_e'(msb_first);
    end else if (lane_fire_s) begin
      mask_r <= mask_r & ~pick_onehot_s;
    end else begin
      mask_r <= mask_r;
    end
  end

endmodule

// File: tb/tb_word_lane_serializer.sv
// Directed bench for word_lane_serializer: reset, lane order, enables,
// stalls, back-to-back words, empty words and mid-word reset.
module tb_word_lane_serializer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_be;
  logic        msb_first;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;

  int tests;
  int fails;

  word_lane_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_be     (in_be),
    .msb_first (msb_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input logic [7:0] d, input logic [1:0] i, input logic l);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_idx"},   32'(out_idx),   32'(i));
    chk({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_data"},  32'(out_data),  32'd0);
  endtask

  logic [7:0] exp_d [8];
  logic [1:0] exp_i [4];

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    in_be     = 4'hF;
    msb_first = 1'b1;
    out_ready = 1'b1;

    // Reset held two cycles with a word offered.
    tick();
    chk("rst1_in_ready", 32'(in_ready), 32'd0);
    chk_idle("rst1");
    tick();
    chk("rst2_in_ready", 32'(in_ready), 32'd0);
    chk_idle("rst2");
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_idle("rel");

    // Full word, MSB first.
    in_data   = 32'h12345678;
    in_be     = 4'hF;
    msb_first = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_d[0] = 8'h12; exp_d[1] = 8'h34; exp_d[2] = 8'h56; exp_d[3] = 8'h78;
    exp_i[0] = 2'd3;  exp_i[1] = 2'd2;  exp_i[2] = 2'd1;  exp_i[3] = 2'd0;
    for (int k = 0; k < 4; k++) begin
      chk_lane($sformatf("msb%0d", k), exp_d[k], exp_i[k], k == 3);
      chk($sformatf("msb%0d_in_ready", k), 32'(in_ready), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk_idle("msb_end");

    // Sparse enables, LSB first.
    in_be     = 4'b1010;
    msb_first = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_lane("lsb0", 8'h56, 2'd1, 1'b0);
    tick();
    chk_lane("lsb1", 8'h12, 2'd3, 1'b1);
    tick();
    chk_idle("lsb_end");

    // Alternating back-pressure: each lane stalls one cycle then fires.
    in_be     = 4'hF;
    msb_first = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b0;
      #1;
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      tick();
      chk_lane($sformatf("stall%0d_hold", k), exp_d[k], exp_i[k], k == 3);
      out_ready = 1'b1;
      tick();
    end
    chk_idle("stall_end");

    // Back-to-back words with in_valid held.
    in_data  = 32'hAABBCCDD;
    in_valid = 1'b1;
    tick();
    in_data  = 32'h11223344;
    exp_d[0] = 8'hAA; exp_d[1] = 8'hBB; exp_d[2] = 8'hCC; exp_d[3] = 8'hDD;
    exp_d[4] = 8'h11; exp_d[5] = 8'h22; exp_d[6] = 8'h33; exp_d[7] = 8'h44;
    for (int k = 0; k < 8; k++) begin
      chk_lane($sformatf("b2b%0d", k), exp_d[k], exp_i[k % 4], (k % 4) == 3);
      if (k < 4) begin
        chk($sformatf("b2b%0d_in_ready", k), 32'(in_ready), (k == 3) ? 32'd1 : 32'd0);
      end
      tick();
      if (k == 3) in_valid = 1'b0;
    end
    chk_idle("b2b_end");

    // Empty word is swallowed without output.
    in_data  = 32'h55555555;
    in_be    = 4'h0;
    in_valid = 1'b1;
    #1;
    chk("empty_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_idle("empty");
    chk("empty_after_in_ready", 32'(in_ready), 32'd1);

    // Full word, then reset after two lanes drops the rest.
    in_data  = 32'hCAFEF00D;
    in_be    = 4'hF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_lane("mid0", 8'hCA, 2'd3, 1'b0);
    tick();
    chk_lane("mid1", 8'hFE, 2'd2, 1'b0);
    tick();
    chk_lane("mid2", 8'hF0, 2'd1, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_in_ready_rel", 32'(in_ready), 32'd1);
    tick();
    chk_idle("mid_rst_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
